sifh_hist_peak: RTL and testbench

- Parametrised successor to the serial SiFH histogram builder and peak detector.
- Pass 0 (coarse) builds one histogram per pixel from timestamp MSBs. Pass 1 (fine) zooms a 2^NB-LSB window around each pixel's coarse peak and re-histograms at full resolution.
- At frame end it emits the per-pixel peak timestamp.
- Sits between the TDC/data filter stream and the algebraic/readout stage. Adds a valid/ready handshake, configurable pixel count, tie rule, read-modify-write hazard forwarding and clean synchronous reset.

---
 rtl/sifh_hist_peak.sv | 272 +++++++++++++++++++++++++++
 tb/tb_sifh_hist_peak.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sifh_hist_peak.sv
// sifh_hist_peak: two-pass (coarse, then zoomed fine) per-pixel histogram builder and peak finder.
// Optional macro SIFH_SAT_EN: saturating bin counters plus a sticky sat_flag output.
module sifh_hist_peak #(
    parameter int unsigned NP       = 12,
    parameter int unsigned NB       = 6,
    parameter int unsigned PIXELS   = 4,
    parameter int unsigned DATA_NUM = 4,
    parameter int unsigned ACQ_NUM  = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NP-1:0]        in_data,
    output logic                 out_valid,
    output logic [NP*PIXELS-1:0] out_result,
`ifdef SIFH_SAT_EN
    output logic                 sat_flag,
`endif
    output logic                 pass_id
);

    localparam int unsigned PW    = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int unsigned SW    = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam int unsigned QW    = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
    localparam int unsigned AW    = PW + NB;
    localparam int unsigned WORDS = PIXELS << NB;

    localparam logic signed [NP:0] HalfBin = (NP+1)'(1 << (NP - NB - 1));
    localparam logic signed [NP:0] HalfWin = (NP+1)'(1 << (NB - 1));
    localparam logic signed [NP:0] LoMax   = (NP+1)'((1 << NP) - (1 << NB));

    typedef enum logic [1:0] {StCoarse, StDrain0, StFine, StDrain1} state_e;

    state_e        state_q;
    logic [1:0]    drain_cnt_q;
    logic [SW-1:0] smp_q;
    logic [PW-1:0] pix_q;
    logic [QW-1:0] acq_q;
    logic          ready_q;
    logic          pass_q;
    logic          out_valid_q;

    logic accept, last_smp, last_pix, last_acq;
    logic in_drain, first_drain, drain_end, result_load;

    assign accept      = in_valid && ready_q;
    assign last_smp    = (smp_q == SW'(DATA_NUM - 1));
    assign last_pix    = (pix_q == PW'(PIXELS - 1));
    assign last_acq    = (acq_q == QW'(ACQ_NUM - 1));
    assign in_drain    = (state_q == StDrain0) || (state_q == StDrain1);
    assign first_drain = in_drain && (drain_cnt_q == 2'd0);
    assign drain_end   = in_drain && (drain_cnt_q == 2'd2);
    // The last sample's peak compare happens in the middle drain cycle.
    assign result_load = (state_q == StDrain1) && (drain_cnt_q == 2'd1);

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= StCoarse;
            drain_cnt_q <= '0;
            smp_q       <= '0;
            pix_q       <= '0;
            acq_q       <= '0;
            ready_q     <= 1'b1;
            pass_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= result_load;
            case (state_q)
                StCoarse, StFine: begin
                    if (accept) begin
                        smp_q <= last_smp ? '0 : smp_q + 1'b1;
                        if (last_smp) begin
                            pix_q <= last_pix ? '0 : pix_q + 1'b1;
                            if (last_pix) begin
                                acq_q <= last_acq ? '0 : acq_q + 1'b1;
                            end
                        end
                        if (last_smp && last_pix && last_acq) begin
                            state_q     <= (state_q == StCoarse) ? StDrain0 : StDrain1;
                            drain_cnt_q <= '0;
                            ready_q     <= 1'b0;
                        end
                    end
                end
                StDrain0, StDrain1: begin
                    drain_cnt_q <= drain_cnt_q + 2'd1;
                    if (drain_end) begin
                        state_q <= (state_q == StDrain0) ? StFine : StCoarse;
                        pass_q  <= (state_q == StDrain0);
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= StCoarse;
            endcase
        end
    end

    assign in_ready  = ready_q;
    assign pass_id   = pass_q;
    assign out_valid = out_valid_q;

    // Histogram RAM with lazy clear through per-word valid bits.
    logic [CNT_W-1:0] mem [WORDS];
    logic [WORDS-1:0] vld_q;

    logic [NP-1:0] win_lo_q [PIXELS];
    logic [NP-1:0] win_c_q  [PIXELS];
    logic [NP-1:0] win_lo_d [PIXELS];
    logic [NP-1:0] win_c_d  [PIXELS];

    logic             fine;
    logic [NP-1:0]    cur_lo, cur_hi, fine_off;
    logic             in_window;
    logic [NB-1:0]    s0_bin;
    logic             s0_hit;
    logic [AW-1:0]    s0_addr;
    logic [CNT_W-1:0] s0_old;

    logic             s1_hit;
    logic [AW-1:0]    s1_addr;
    logic [CNT_W-1:0] s1_old;
    logic [CNT_W-1:0] s1_new;

    logic             s2_hit;
    logic [PW-1:0]    s2_pix;
    logic [NB-1:0]    s2_bin;
    logic [CNT_W-1:0] s2_cnt;

    assign fine      = (state_q == StFine);
    assign cur_lo    = win_lo_q[pix_q];
    assign cur_hi    = cur_lo + NP'((1 << NB) - 1);
    assign fine_off  = in_data - cur_lo;
    assign in_window = (in_data >= cur_lo) && (in_data <= cur_hi);
    assign s0_bin    = fine ? fine_off[NB-1:0] : in_data[NP-1 -: NB];
    assign s0_hit    = accept && (!fine || in_window);
    assign s0_addr   = {pix_q, s0_bin};

    // Forward the in-flight S1 write so back-to-back hits on one word stay exact.
    assign s0_old = (s1_hit && (s1_addr == s0_addr)) ? s1_new
                  : (vld_q[s0_addr] ? mem[s0_addr] : '0);

`ifdef SIFH_SAT_EN
    logic sat_block;
    logic sat_q;

    assign sat_block = s1_hit && (s1_old == {CNT_W{1'b1}});
    assign s1_new    = sat_block ? s1_old : s1_old + 1'b1;

    always_ff @(posedge clk) begin
        if (res || ((state_q == StDrain1) && drain_end)) begin
            sat_q <= 1'b0;
        end else if (sat_block) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    assign s1_new = s1_old + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            s1_hit <= 1'b0;
            s2_hit <= 1'b0;
        end else begin
            s1_hit <= s0_hit;
            s2_hit <= s1_hit;
        end
        s1_addr <= s0_addr;
        s1_old  <= s0_old;
        s2_pix  <= s1_addr[AW-1:NB];
        s2_bin  <= s1_addr[NB-1:0];
        s2_cnt  <= s1_new;
    end

    always_ff @(posedge clk) begin
        if (s1_hit) begin
            mem[s1_addr] <= s1_new;
        end
    end

    // Clearing wins over the final write of a pass landing in the same cycle.
    always_ff @(posedge clk) begin
        if (res || first_drain) begin
            vld_q <= '0;
        end else if (s1_hit) begin
            vld_q[s1_addr] <= 1'b1;
        end
    end

    logic [CNT_W-1:0] cnt_max_q  [PIXELS];
    logic [CNT_W-1:0] cnt_max_d  [PIXELS];
    logic [NB-1:0]    peak_bin_q [PIXELS];
    logic [NB-1:0]    peak_bin_d [PIXELS];

    always_comb begin
        cnt_max_d  = cnt_max_q;
        peak_bin_d = peak_bin_q;
        if (s2_hit && (s2_cnt > cnt_max_q[s2_pix])) begin
            cnt_max_d[s2_pix]  = s2_cnt;
            peak_bin_d[s2_pix] = s2_bin;
        end
    end

    always_ff @(posedge clk) begin
        if (res || drain_end) begin
            for (int p = 0; p < PIXELS; p++) begin
                cnt_max_q[p]  <= '0;
                peak_bin_q[p] <= '0;
            end
        end else begin
            cnt_max_q  <= cnt_max_d;
            peak_bin_q <= peak_bin_d;
        end
    end

    always_comb begin
        logic signed [NP:0] c_s;
        logic signed [NP:0] lo_s;
        c_s  = '0;
        lo_s = '0;
        for (int p = 0; p < PIXELS; p++) begin
            c_s  = $signed({1'b0, peak_bin_q[p], {(NP-NB){1'b0}}}) + HalfBin;
            lo_s = c_s - HalfWin;
            if (lo_s[NP]) begin
                lo_s = '0;
            end else if (lo_s > LoMax) begin
                lo_s = LoMax;
            end
            win_c_d[p]  = c_s[NP-1:0];
            win_lo_d[p] = lo_s[NP-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            for (int p = 0; p < PIXELS; p++) begin
                win_lo_q[p] <= '0;
                win_c_q[p]  <= '0;
            end
        end else if ((state_q == StDrain0) && drain_end) begin
            win_lo_q <= win_lo_d;
            win_c_q  <= win_c_d;
        end
    end

    logic [NP*PIXELS-1:0] result_d;
    logic [NP*PIXELS-1:0] out_result_q;

    always_comb begin
        result_d = '0;
        for (int p = 0; p < PIXELS; p++) begin
            // An empty fine histogram falls back to the coarse bin centre.
            result_d[p*NP +: NP] = (cnt_max_d[p] == '0) ? win_c_q[p]
                                 : win_lo_q[p] + NP'(peak_bin_d[p]);
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            out_result_q <= '0;
        end else if (result_load) begin
            out_result_q <= result_d;
        end
    end

    assign out_result = out_result_q;

endmodule

// File: tb/tb_sifh_hist_peak.sv
// Directed bench for sifh_hist_peak: default 12-bit instance plus a 10-bit instance for clamping.
module tb_sifh_hist_peak;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] data12 = '0;
    logic [9:0]  data10 = '0;

    logic        in_ready, out_valid, pass_id;
    logic [47:0] out_result;
    logic        rdy10, ov10, pid10;
    logic [39:0] res10;

    int vec_cnt   = 0;
    int err_cnt   = 0;
    int ov_pulses = 0;

    int          drain0_len, drain1_len, ov_delay;
    logic [47:0] ov_result;
    logic [39:0] ov_res10;
    logic [7:0]  ov_max0;
    logic        pid_at_abort;

`ifdef SIFH_SAT_EN
    logic        sat0, sat10, sat_s, rdy_s, ov_s, pid_s;
    logic [47:0] res_s;
    logic [3:0]  sat_max0;
    logic        sat_drain;
    logic [47:0] ov_res_s;
`endif

    sifh_hist_peak dut (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready), .in_data(data12),
        .out_valid(out_valid), .out_result(out_result),
`ifdef SIFH_SAT_EN
        .sat_flag(sat0),
`endif
        .pass_id(pass_id)
    );

    sifh_hist_peak #(.NP(10), .NB(6)) dut10 (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(rdy10), .in_data(data10),
        .out_valid(ov10), .out_result(res10),
`ifdef SIFH_SAT_EN
        .sat_flag(sat10),
`endif
        .pass_id(pid10)
    );

`ifdef SIFH_SAT_EN
    sifh_hist_peak #(.CNT_W(4)) dut_sat (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(rdy_s), .in_data(data12),
        .out_valid(ov_s), .out_result(res_s), .sat_flag(sat_s), .pass_id(pid_s)
    );
`endif

    always @(negedge clk) begin
        if (out_valid === 1'b1) ov_pulses++;
    end

    // mode 0: constant per pixel; 1: pixel 0 majority; 2: pixel 0 alternating tie
    function automatic logic [11:0] pat12(input int mode, input int p, input int k);
        case (mode)
            0:       return 12'h400 + 12'(16 * p);
            1:       return (p == 0) ? ((k == 3) ? 12'h000 : 12'h400) : 12'h200;
            default: return (p == 0) ? ((k % 2 == 0) ? 12'h100 : 12'h800) : 12'h200;
        endcase
    endfunction

    function automatic logic [9:0] pat10(input int p);
        case (p)
            0:       return 10'h3FF;
            1:       return 10'h000;
            default: return 10'h200;
        endcase
    endfunction

    task automatic push(input logic [11:0] d, input logic [9:0] d10, input bit rnd);
        int n;
        if (rnd) begin
            while ($urandom_range(1, 0) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        data12   = d;
        data10   = d10;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL push_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(output int low_cycles);
        low_cycles = 0;
        in_valid   = 1'b0;
        while (!in_ready && low_cycles < 20) begin
`ifdef SIFH_SAT_EN
            if (low_cycles == 2) begin
                sat_max0  = dut_sat.cnt_max_q[0];
                sat_drain = sat_s;
            end
`endif
            low_cycles++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_frame(input int mode, input bit rnd, input int abort_at);
        int idx;
        for (int pass = 0; pass < 2; pass++) begin
            idx = 0;
            for (int a = 0; a < 8; a++) begin
                for (int p = 0; p < 4; p++) begin
                    for (int k = 0; k < 4; k++) begin
                        if (pass == 1 && idx == abort_at) begin
                            pid_at_abort = pass_id;
                            in_valid = 1'b0;
                            res = 1'b1;
                            @(posedge clk); #1;
                            res = 1'b0;
                            return;
                        end
                        push(pat12(mode, p, k), pat10(p), rnd);
                        idx++;
                    end
                end
            end
            if (pass == 0) wait_ready(drain0_len);
        end
        in_valid   = 1'b0;
        drain1_len = 0;
        ov_delay   = 0;
        for (int c = 1; c <= 6; c++) begin
            if (!in_ready) drain1_len++;
            if (out_valid && ov_delay == 0) begin
                ov_delay  = c;
                ov_result = out_result;
                ov_res10  = res10;
                ov_max0   = dut.cnt_max_q[0];
`ifdef SIFH_SAT_EN
                ov_res_s  = res_s;
`endif
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        res = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %0b need 1", in_ready); end
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_ovalid: got %0b need 0", out_valid); end
        vec_cnt++; if (out_result !== 48'h0) begin err_cnt++; $display("FAIL reset_result: got %h need 0", out_result); end
        vec_cnt++; if (pass_id !== 1'b0) begin err_cnt++; $display("FAIL reset_pass: got %0b need 0", pass_id); end
        res = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_defaults;
        int p0;
        p0 = ov_pulses;
        run_frame(0, 1'b0, -1);
        vec_cnt++; if (drain0_len !== 3) begin err_cnt++; $display("FAIL drain0_len: got %0d need 3", drain0_len); end
        vec_cnt++; if (drain1_len !== 3) begin err_cnt++; $display("FAIL drain1_len: got %0d need 3", drain1_len); end
        vec_cnt++; if (ov_delay !== 3) begin err_cnt++; $display("FAIL ov_delay: got %0d need 3", ov_delay); end
        vec_cnt++; if (ov_result !== 48'h430_420_410_400) begin err_cnt++; $display("FAIL defaults_result: got %h need 430420410400", ov_result); end
        vec_cnt++; if (ov_max0 !== 8'd32) begin err_cnt++; $display("FAIL b2b_count: got %0d need 32", ov_max0); end
        vec_cnt++; if (ov_pulses - p0 !== 1) begin err_cnt++; $display("FAIL pulse_count: got %0d need 1", ov_pulses - p0); end
        vec_cnt++; if (out_result !== 48'h430_420_410_400) begin err_cnt++; $display("FAIL result_hold: got %h need 430420410400", out_result); end
`ifdef SIFH_SAT_EN
        vec_cnt++; if (sat_max0 !== 4'd15) begin err_cnt++; $display("FAIL sat_count: got %0d need 15", sat_max0); end
        vec_cnt++; if (sat_drain !== 1'b1) begin err_cnt++; $display("FAIL sat_flag_set: got %0b need 1", sat_drain); end
        vec_cnt++; if (ov_res_s !== 48'h430_420_410_400) begin err_cnt++; $display("FAIL sat_result: got %h need 430420410400", ov_res_s); end
        vec_cnt++; if (sat_s !== 1'b0) begin err_cnt++; $display("FAIL sat_flag_clear: got %0b need 0", sat_s); end
`endif
    endtask

    task automatic test_clamp;
        run_frame(0, 1'b0, -1);
        vec_cnt++; if (ov_res10 !== {10'h200, 10'h200, 10'h000, 10'h3FF}) begin err_cnt++; $display("FAIL clamp_result: got %h need %h", ov_res10, {10'h200, 10'h200, 10'h000, 10'h3FF}); end
    endtask

    task automatic test_majority;
        run_frame(1, 1'b0, -1);
        vec_cnt++; if (ov_result !== 48'h200_200_200_400) begin err_cnt++; $display("FAIL majority_result: got %h need 200200200400", ov_result); end
        vec_cnt++; if (ov_max0 !== 8'd24) begin err_cnt++; $display("FAIL majority_count: got %0d need 24", ov_max0); end
    endtask

    task automatic test_tie;
        run_frame(2, 1'b0, -1);
        vec_cnt++; if (ov_result !== 48'h200_200_200_100) begin err_cnt++; $display("FAIL tie_result: got %h need 200200200100", ov_result); end
    endtask

    task automatic test_random_valid;
        run_frame(0, 1'b1, -1);
        vec_cnt++; if (ov_result !== 48'h430_420_410_400) begin err_cnt++; $display("FAIL random_result: got %h need 430420410400", ov_result); end
        vec_cnt++; if (ov_max0 !== 8'd32) begin err_cnt++; $display("FAIL random_count: got %0d need 32", ov_max0); end
        vec_cnt++; if (ov_delay !== 3) begin err_cnt++; $display("FAIL random_ov_delay: got %0d need 3", ov_delay); end
    endtask

    task automatic test_reset_abort;
        int p0;
        p0 = ov_pulses;
        run_frame(0, 1'b0, 60);
        vec_cnt++; if (pid_at_abort !== 1'b1) begin err_cnt++; $display("FAIL fine_pass_id: got %0b need 1", pid_at_abort); end
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL abort_ready: got %0b need 1", in_ready); end
        vec_cnt++; if (out_result !== 48'h0) begin err_cnt++; $display("FAIL abort_result: got %h need 0", out_result); end
        vec_cnt++; if (pass_id !== 1'b0) begin err_cnt++; $display("FAIL abort_pass: got %0b need 0", pass_id); end
        run_frame(0, 1'b0, -1);
        vec_cnt++; if (ov_pulses - p0 !== 1) begin err_cnt++; $display("FAIL abort_pulses: got %0d need 1", ov_pulses - p0); end
        vec_cnt++; if (ov_result !== 48'h430_420_410_400) begin err_cnt++; $display("FAIL abort_next_result: got %h need 430420410400", ov_result); end
        vec_cnt++; if (ov_max0 !== 8'd32) begin err_cnt++; $display("FAIL abort_next_count: got %0d need 32", ov_max0); end
    endtask

    initial begin
        test_reset;
        test_defaults;
        test_clamp;
        test_majority;
        test_tie;
        test_random_valid;
        test_reset_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
